// File: rtl/rmii_rx_frame.sv
// RMII receive framer: strips preamble/SFD, assembles dibits into bytes,
// checks CRC-32 and length, and reports one status pulse per frame.
module rmii_rx_frame #(
    parameter int MIN_FRAME_BYTES     = 64,
    parameter int MAX_FRAME_BYTES     = 1522,
    parameter int MIN_PREAMBLE_DIBITS = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        crs_dv,
    input  logic [1:0]  rxd,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [10:0] frame_len
);

    localparam logic [1:0]  ST_DROP     = 2'd0;
    localparam logic [1:0]  ST_IDLE     = 2'd1;
    localparam logic [1:0]  ST_PREAMBLE = 2'd2;
    localparam logic [1:0]  ST_DATA     = 2'd3;

    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [10:0] LEN_MIN     = 11'(MIN_FRAME_BYTES);
    localparam logic [10:0] LEN_MAX     = 11'(MAX_FRAME_BYTES);
    localparam logic [10:0] LEN_OVF     = 11'(MAX_FRAME_BYTES + 1);
    localparam logic [4:0]  PRE_MIN     = 5'(MIN_PREAMBLE_DIBITS);
    localparam logic [4:0]  PRE_SAT     = 5'd31;

    // Two-stage line sampler
    logic       s0_crs_q, s1_crs_q;
    logic [1:0] s0_rxd_q, s1_rxd_q;

    // NOTE: the sampler is left out of reset on purpose; it keeps tracking the
    // live line so a frame still in flight at reset release is not mistaken
    // for an end-of-frame gap, and the FSM stays in DROP until the real gap.
    always_ff @(posedge clk) begin
        s0_crs_q <= crs_dv;
        s0_rxd_q <= rxd;
        s1_crs_q <= s0_crs_q;
        s1_rxd_q <= s0_rxd_q;
    end

    // A low CRS_DV next to a high one is the PHY's end-of-frame toggling,
    // so the s1 dibit still counts as data.
    logic dibit_vld, line_end;
    assign dibit_vld = s1_crs_q | s0_crs_q;
    assign line_end  = ~dibit_vld;

    // Reflected CRC-32 over one dibit, bit 0 first
    function automatic logic [31:0] crc_dibit(input logic [31:0] crc, input logic [1:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 2; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ CRC_POLY;
            else             c = c >> 1;
        end
        return c;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [4:0]  pre_cnt_q, pre_cnt_d;
    logic [5:0]  shift_q, shift_d;
    logic [1:0]  phase_q, phase_d;
    logic [10:0] len_q, len_d;
    logic [31:0] crc_q, crc_d;

    logic        byte_stb, byte_sof, end_stb;
    logic [7:0]  byte_data;

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        shift_d   = shift_q;
        phase_d   = phase_q;
        len_d     = len_q;
        crc_d     = crc_q;
        byte_stb  = 1'b0;
        byte_sof  = 1'b0;
        end_stb   = 1'b0;
        byte_data = {s1_rxd_q, shift_q};

        case (state_q)
            ST_DROP: begin
                if (line_end) state_d = ST_IDLE;
            end

            ST_IDLE: begin
                if (dibit_vld) begin
                    if (s1_rxd_q == 2'b01) begin
                        state_d   = ST_PREAMBLE;
                        pre_cnt_d = 5'd1;
                    end else if (s1_rxd_q != 2'b00) begin
                        state_d = ST_DROP;
                    end
                end
            end

            ST_PREAMBLE: begin
                if (line_end) begin
                    state_d = ST_IDLE;
                end else if (s1_rxd_q == 2'b01) begin
                    if (pre_cnt_q != PRE_SAT) pre_cnt_d = pre_cnt_q + 5'd1;
                end else if (s1_rxd_q == 2'b11 && pre_cnt_q >= PRE_MIN) begin
                    state_d = ST_DATA;
                    crc_d   = '1;
                    len_d   = '0;
                    phase_d = '0;
                end else begin
                    state_d = ST_DROP;
                end
            end

            ST_DATA: begin
                if (line_end) begin
                    state_d = ST_IDLE;
                    end_stb = 1'b1;
                end else begin
                    crc_d   = crc_dibit(crc_q, s1_rxd_q);
                    shift_d = {s1_rxd_q, shift_q[5:2]};
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd3) begin
                        // Bytes past the maximum are counted as overflow, never emitted
                        if (len_q < LEN_MAX) begin
                            byte_stb = 1'b1;
                            byte_sof = (len_q == 11'd0);
                            len_d    = len_q + 11'd1;
                        end else begin
                            len_d = LEN_OVF;
                        end
                    end
                end
            end

            default: state_d = ST_DROP;
        endcase
    end

    logic frame_good;
    assign frame_good = (crc_q == CRC_RESIDUE) && (len_q >= LEN_MIN) &&
                        (len_q <= LEN_MAX) && (phase_q == 2'd0);

    logic        done_pend_q, ok_pend_q;
    logic [10:0] len_pend_q;
    logic [7:0]  rx_data_q;
    logic        rx_valid_q, rx_sof_q;
    logic        frame_done_q, frame_ok_q, frame_err_q;
    logic [10:0] frame_len_q;

    // NOTE: all state below uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_DROP;
            pre_cnt_q    <= '0;
            shift_q      <= '0;
            phase_q      <= '0;
            len_q        <= '0;
            crc_q        <= '1;
            done_pend_q  <= 1'b0;
            ok_pend_q    <= 1'b0;
            len_pend_q   <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_sof_q     <= 1'b0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_len_q  <= '0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            shift_q    <= shift_d;
            phase_q    <= phase_d;
            len_q      <= len_d;
            crc_q      <= crc_d;

            rx_valid_q <= byte_stb;
            rx_sof_q   <= byte_sof;
            if (byte_stb) rx_data_q <= byte_data;

            // Frame verdict is captured at end detect and published one cycle later
            done_pend_q <= end_stb;
            if (end_stb) begin
                ok_pend_q  <= frame_good;
                len_pend_q <= len_q;
            end

            frame_done_q <= done_pend_q;
            frame_ok_q   <= done_pend_q & ok_pend_q;
            frame_err_q  <= done_pend_q & ~ok_pend_q;
            if (done_pend_q) frame_len_q <= len_pend_q;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_sof     = rx_sof_q;
    assign frame_done = frame_done_q;
    assign frame_ok   = frame_ok_q;
    assign frame_err  = frame_err_q;
    assign frame_len  = frame_len_q;

endmodule
